// File: rtl/mem_arbiter_if.sv
// Bundles the IFU fetch port, LSU data port and the shared RAM port of mem_arbiter.
// The arbiter takes the slave view; requesters and the RAM model drive the master view.
interface mem_arbiter_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [63:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;
    logic        ifu_rsp_err;

    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [63:0] lsu_addr;
    logic        lsu_wen;
    logic [63:0] lsu_wdata;
    logic [7:0]  lsu_wstrb;
    logic        lsu_rsp_valid;
    logic [63:0] lsu_rsp_rdata;
    logic        lsu_rsp_err;

    logic        ram_en;
    logic [63:0] ram_addr;
    logic        ram_wen;
    logic [63:0] ram_wdata;
    logic [63:0] ram_wmask;
    logic [63:0] ram_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wstrb,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
        output ram_en, ram_addr, ram_wen, ram_wdata, ram_wmask,
        input  ram_rdata
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wstrb,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
        input  ram_en, ram_addr, ram_wen, ram_wdata, ram_wmask,
        output ram_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (IFU fetch, LSU data) onto one combinational-read RAM port.
// LSU has priority; IFU is forced through after STARVE_LIMIT consecutive LSU wins.
module mem_arbiter #(
    parameter logic [63:0] RAM_BASE     = 64'h0000_0000_8000_0000,
    parameter logic [63:0] RAM_BYTES    = 64'h0000_0000_0800_0000,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    // Lower bound is checked first so the subtraction can never wrap into range.
    function automatic logic in_range(input logic [63:0] addr);
        return (addr >= RAM_BASE) && ((addr - RAM_BASE) < RAM_BYTES);
    endfunction

    function automatic logic [63:0] expand_strb(input logic [7:0] strb);
        logic [63:0] mask;
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            mask[8*i +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

    function automatic logic [31:0] sel_word(input logic [63:0] data, input logic hi);
        return hi ? data[63:32] : data[31:0];
    endfunction

    logic [3:0]  starve_cnt;
    logic        starve_hit_p0;
    logic        ifu_gnt_p0;
    logic        lsu_gnt_p0;
    logic        ifu_hit_p0;
    logic        lsu_hit_p0;

    logic        ifu_vld_p1;
    logic [31:0] ifu_data_p1;
    logic        ifu_err_p1;
    logic        lsu_vld_p1;
    logic [63:0] lsu_data_p1;
    logic        lsu_err_p1;

    // Stage p0: grant, address decode and RAM drive, all in the accept cycle
    assign starve_hit_p0 = (starve_cnt == STARVE_MAX);
    assign ifu_hit_p0    = in_range(bus.ifu_addr);
    assign lsu_hit_p0    = in_range(bus.lsu_addr);

    always_comb begin
        ifu_gnt_p0 = 1'b0;
        lsu_gnt_p0 = 1'b0;
        if (!rst) begin
            if (bus.lsu_req_valid && !(bus.ifu_req_valid && starve_hit_p0)) begin
                lsu_gnt_p0 = 1'b1;
            end else if (bus.ifu_req_valid) begin
                ifu_gnt_p0 = 1'b1;
            end
        end
    end

    assign bus.ifu_req_ready = ifu_gnt_p0;
    assign bus.lsu_req_ready = lsu_gnt_p0;

    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wen   = 1'b0;
        bus.ram_wdata = '0;
        bus.ram_wmask = '0;
        if (lsu_gnt_p0) begin
            bus.ram_en    = lsu_hit_p0;
            bus.ram_addr  = bus.lsu_addr;
            bus.ram_wen   = bus.lsu_wen && lsu_hit_p0;
            bus.ram_wdata = bus.lsu_wdata;
            bus.ram_wmask = bus.lsu_wen ? expand_strb(bus.lsu_wstrb) : 64'h0;
        end else if (ifu_gnt_p0) begin
            bus.ram_en    = ifu_hit_p0;
            bus.ram_addr  = bus.ifu_addr;
        end
    end

    // Starvation counter tracks LSU wins only while IFU is actually waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!bus.ifu_req_valid || ifu_gnt_p0) begin
            starve_cnt <= '0;
        end else if (lsu_gnt_p0 && !starve_hit_p0) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Stage p1: registered responses, one cycle after accept
    always_ff @(posedge clk) begin
        if (rst) begin
            ifu_vld_p1  <= 1'b0;
            ifu_data_p1 <= '0;
            ifu_err_p1  <= 1'b0;
        end else begin
            ifu_vld_p1 <= ifu_gnt_p0;
            if (ifu_gnt_p0) begin
                ifu_data_p1 <= ifu_hit_p0 ? sel_word(bus.ram_rdata, bus.ifu_addr[2]) : 32'h0;
                ifu_err_p1  <= !ifu_hit_p0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_vld_p1  <= 1'b0;
            lsu_data_p1 <= '0;
            lsu_err_p1  <= 1'b0;
        end else begin
            lsu_vld_p1 <= lsu_gnt_p0;
            if (lsu_gnt_p0) begin
                lsu_data_p1 <= (lsu_hit_p0 && !bus.lsu_wen) ? bus.ram_rdata : 64'h0;
                lsu_err_p1  <= !lsu_hit_p0;
            end
        end
    end

    assign bus.ifu_rsp_valid = ifu_vld_p1;
    assign bus.ifu_rsp_data  = ifu_data_p1;
    assign bus.ifu_rsp_err   = ifu_err_p1;
    assign bus.lsu_rsp_valid = lsu_vld_p1;
    assign bus.lsu_rsp_rdata = lsu_data_p1;
    assign bus.lsu_rsp_err   = lsu_err_p1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: writes, fetch word select, range errors,
// starvation pattern, alternation and reset behaviour.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ifu_req_valid = 1'b0;
        bus.ifu_addr      = '0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_addr      = '0;
        bus.lsu_wen       = 1'b0;
        bus.lsu_wdata     = '0;
        bus.lsu_wstrb     = '0;
        bus.ram_rdata     = '0;
    endtask

    initial begin
        logic exp_ifu;
        n_checks = 0;
        n_fail   = 0;
        idle();
        rst = 1'b1;
        bus.ifu_req_valid = 1'b1;
        bus.lsu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h8000_0000;
        bus.lsu_addr      = 64'h8000_0008;
        #1;
        check_val("rst_ifu_ready", bus.ifu_req_ready, 0);
        check_val("rst_lsu_ready", bus.lsu_req_ready, 0);
        check_val("rst_ram_en", bus.ram_en, 0);
        step();
        step();
        check_val("rst_ifu_rsp_valid", bus.ifu_rsp_valid, 0);
        check_val("rst_lsu_rsp_valid", bus.lsu_rsp_valid, 0);
        check_val("rst_ifu_rsp_data", bus.ifu_rsp_data, 0);
        check_val("rst_lsu_rsp_rdata", bus.lsu_rsp_rdata, 0);
        check_val("rst_lsu_rsp_err", bus.lsu_rsp_err, 0);
        rst = 1'b0;
        idle();
        #1;
        check_val("idle_ram_en", bus.ram_en, 0);
        check_val("idle_readies", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
        step();

        // LSU partial write
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 64'h8000_0010;
        bus.lsu_wen       = 1'b1;
        bus.lsu_wdata     = 64'h1122_3344_5566_7788;
        bus.lsu_wstrb     = 8'h0F;
        #1;
        check_val("wr_lsu_ready", bus.lsu_req_ready, 1);
        check_val("wr_ifu_ready", bus.ifu_req_ready, 0);
        check_val("wr_ram_en", bus.ram_en, 1);
        check_val("wr_ram_wen", bus.ram_wen, 1);
        check_val("wr_ram_addr", bus.ram_addr, 64'h8000_0010);
        check_val("wr_ram_wdata", bus.ram_wdata, 64'h1122_3344_5566_7788);
        check_val("wr_ram_wmask", bus.ram_wmask, 64'h0000_0000_FFFF_FFFF);
        step();
        idle();
        check_val("wr_rsp_valid", bus.lsu_rsp_valid, 1);
        check_val("wr_rsp_rdata", bus.lsu_rsp_rdata, 0);
        check_val("wr_rsp_err", bus.lsu_rsp_err, 0);
        check_val("wr_ifu_rsp_valid", bus.ifu_rsp_valid, 0);

        // IFU fetches, upper then lower word, back to back
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h8000_0004;
        bus.ram_rdata     = 64'hAAAA_BBBB_CCCC_DDDD;
        #1;
        check_val("if_ifu_ready", bus.ifu_req_ready, 1);
        check_val("if_ram_en", bus.ram_en, 1);
        check_val("if_ram_wen", bus.ram_wen, 0);
        check_val("if_ram_wmask", bus.ram_wmask, 0);
        check_val("if_ram_wdata", bus.ram_wdata, 0);
        step();
        check_val("if_hi_valid", bus.ifu_rsp_valid, 1);
        check_val("if_hi_data", bus.ifu_rsp_data, 32'hAAAA_BBBB);
        check_val("if_hi_err", bus.ifu_rsp_err, 0);
        bus.ifu_addr = 64'h8000_0000;
        step();
        check_val("if_lo_valid", bus.ifu_rsp_valid, 1);
        check_val("if_lo_data", bus.ifu_rsp_data, 32'hCCCC_DDDD);
        idle();
        step();
        check_val("hold_valid", bus.ifu_rsp_valid, 0);
        check_val("hold_data", bus.ifu_rsp_data, 32'hCCCC_DDDD);

        // LSU read in range, then out-of-range below RAM_BASE
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 64'h8000_0008;
        bus.ram_rdata     = 64'h0123_4567_89AB_CDEF;
        step();
        check_val("rd_rsp_rdata", bus.lsu_rsp_rdata, 64'h0123_4567_89AB_CDEF);
        check_val("rd_rsp_err", bus.lsu_rsp_err, 0);
        bus.lsu_addr = 64'h7FFF_FFF8;
        #1;
        check_val("oor_lsu_ready", bus.lsu_req_ready, 1);
        check_val("oor_lsu_ram_en", bus.ram_en, 0);
        step();
        check_val("oor_lsu_valid", bus.lsu_rsp_valid, 1);
        check_val("oor_lsu_err", bus.lsu_rsp_err, 1);
        check_val("oor_lsu_rdata", bus.lsu_rsp_rdata, 0);

        // IFU one past the end, then the last word in range
        idle();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h8800_0000;
        bus.ram_rdata     = 64'h1111_2222_3333_4444;
        #1;
        check_val("oor_ifu_ready", bus.ifu_req_ready, 1);
        check_val("oor_ifu_ram_en", bus.ram_en, 0);
        step();
        check_val("oor_ifu_valid", bus.ifu_rsp_valid, 1);
        check_val("oor_ifu_err", bus.ifu_rsp_err, 1);
        check_val("oor_ifu_data", bus.ifu_rsp_data, 0);
        bus.ifu_addr = 64'h87FF_FFFC;
        #1;
        check_val("last_ifu_ram_en", bus.ram_en, 1);
        step();
        check_val("last_ifu_err", bus.ifu_rsp_err, 0);
        check_val("last_ifu_data", bus.ifu_rsp_data, 32'h1111_2222);
        idle();
        step();

        // Both requesters held high: LSU x4 then IFU, repeating
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h8000_0100;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 64'h8000_0200;
        #1;
        for (int k = 0; k < 10; k++) begin
            exp_ifu = ((k % 5) == 4);
            check_val($sformatf("starve_ifu_ready_%0d", k), bus.ifu_req_ready, exp_ifu);
            check_val($sformatf("starve_lsu_ready_%0d", k), bus.lsu_req_ready, !exp_ifu);
            step();
            check_val($sformatf("starve_ifu_rsp_%0d", k), bus.ifu_rsp_valid, exp_ifu);
            check_val($sformatf("starve_lsu_rsp_%0d", k), bus.lsu_rsp_valid, !exp_ifu);
        end

        // Alternating single requests, one accept per cycle
        for (int k = 0; k < 6; k++) begin
            bus.ifu_req_valid = ((k % 2) == 0);
            bus.lsu_req_valid = ((k % 2) == 1);
            #1;
            check_val($sformatf("alt_ifu_ready_%0d", k), bus.ifu_req_ready, (k % 2) == 0);
            check_val($sformatf("alt_lsu_ready_%0d", k), bus.lsu_req_ready, (k % 2) == 1);
            step();
            check_val($sformatf("alt_ifu_rsp_%0d", k), bus.ifu_rsp_valid, (k % 2) == 0);
            check_val($sformatf("alt_lsu_rsp_%0d", k), bus.lsu_rsp_valid, (k % 2) == 1);
        end

        // LSU accepted, reset on the following edge
        bus.ifu_req_valid = 1'b1;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_wen       = 1'b0;
        bus.ram_rdata     = 64'hDEAD_BEEF_0BAD_F00D;
        #1;
        check_val("pre_rst_lsu_ready", bus.lsu_req_ready, 1);
        step();
        check_val("pre_rst_lsu_rsp", bus.lsu_rsp_valid, 1);
        check_val("pre_rst_lsu_rdata", bus.lsu_rsp_rdata, 64'hDEAD_BEEF_0BAD_F00D);
        rst         = 1'b1;
        bus.lsu_wen = 1'b1;
        bus.lsu_wstrb = 8'hFF;
        #1;
        check_val("in_rst_ifu_ready", bus.ifu_req_ready, 0);
        check_val("in_rst_lsu_ready", bus.lsu_req_ready, 0);
        check_val("in_rst_ram_en", bus.ram_en, 0);
        check_val("in_rst_ram_wen", bus.ram_wen, 0);
        step();
        check_val("post_rst_lsu_rsp", bus.lsu_rsp_valid, 0);
        check_val("post_rst_ifu_rsp", bus.ifu_rsp_valid, 0);
        check_val("post_rst_lsu_rdata", bus.lsu_rsp_rdata, 0);
        check_val("post_rst_ifu_data", bus.ifu_rsp_data, 0);
        rst         = 1'b0;
        bus.lsu_wen = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_ifu = (k == 4);
            check_val($sformatf("post_rst_ifu_ready_%0d", k), bus.ifu_req_ready, exp_ifu);
            check_val($sformatf("post_rst_lsu_ready_%0d", k), bus.lsu_req_ready, !exp_ifu);
            step();
        end
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: RAM_BASE, 64'h0000_0000_8000_0000, byte address of the first RAM byte.
REQ-002 SHALL have parameter: RAM_BYTES, 64'h0000_0000_0800_0000, RAM size in bytes; must be a multiple of 8.
REQ-003 SHALL have parameter: STARVE_LIMIT, 4, maximum consecutive LSU grants while IFU is waiting; legal range 1..15.
REQ-004 SHALL have port: clk  in  1  single clock, all state updates on its rising edge.
REQ-005 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: ifu_req_valid in 1 / ifu_req_ready out 1 / ifu_addr in 64  instruction fetch request; read only.
REQ-007 SHALL have ports: ifu_rsp_valid out 1 / ifu_rsp_data out 32 / ifu_rsp_err out 1  fetch response.
REQ-008 SHALL have ports: lsu_req_valid in 1 / lsu_req_ready out 1 / lsu_addr in 64 / lsu_wen in 1 / lsu_wdata in 64 / lsu_wstrb in 8  data request; wstrb is a byte strobe.
REQ-009 SHALL have ports: lsu_rsp_valid out 1 / lsu_rsp_rdata out 64 / lsu_rsp_err out 1  data response.
REQ-010 SHALL have ports: ram_en out 1 / ram_addr out 64 / ram_wen out 1 / ram_wdata out 64 / ram_wmask out 64 / ram_rdata in 64  single shared RAM port; read data combinational in the same cycle as ram_en; write committed at the rising edge.

Function
REQ-011 SHALL accept a request when req_valid & req_ready are both high in a cycle ("accept cycle"); at most one request accepted per cycle.
REQ-012 SHALL assert at most one of ifu_req_ready / lsu_req_ready per cycle; ready SHALL depend only on rst, both valids and starve_cnt (no dependence on addresses).
REQ-013 SHALL grant LSU when lsu_req_valid is high, unless ifu_req_valid is high and starve_cnt == STARVE_LIMIT, in which case IFU is granted; IFU alone is granted when only ifu_req_valid is high; no ready when neither valid.
REQ-014 SHALL keep a 4-bit starve_cnt: +1 on each LSU accept while ifu_req_valid is high; cleared on IFU accept or any cycle ifu_req_valid is low; never exceeds STARVE_LIMIT.
REQ-015 SHALL drive in the accept cycle: ram_en = in-range, ram_addr = requester address unmodified (byte address), ram_wen = LSU & lsu_wen & in-range, ram_wdata = lsu_wdata.
REQ-016 SHALL expand ram_wmask[8i+7:8i] = {8{lsu_wstrb[i]}}; ram_wmask, ram_wdata, ram_wen SHALL be 0 for IFU grants and idle cycles; ram_en 0 when idle.
REQ-017 SHALL define in-range as RAM_BASE <= addr and addr - RAM_BASE < RAM_BYTES, computed in 64-bit unsigned arithmetic without wrap into range.
REQ-018 SHALL respond exactly 1 cycle after accept: rsp_valid high for one cycle on the accepted requester only; responses have no backpressure.
REQ-019 SHALL register IFU data as ifu_rsp_data = addr[2] ? ram_rdata[63:32] : ram_rdata[31:0], captured in the accept cycle.
REQ-020 SHALL register lsu_rsp_rdata = ram_rdata for LSU reads and 64'h0 for LSU writes.
REQ-021 SHALL, for out-of-range requests, not touch the RAM, and respond with rsp_err = 1 and data 0; in-range responses have rsp_err = 0.
REQ-022 SHALL hold response data/err stable when rsp_valid is low (last value retained) except at reset.
REQ-023 SHALL support back-to-back accepts every cycle, including IFU-then-LSU alternation, with no bubble.

Reset
REQ-024 SHALL, while rst is high at a rising edge, clear starve_cnt, ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err, lsu_rsp_err, ifu_rsp_data, lsu_rsp_rdata to 0.
REQ-025 SHALL force both req_ready and ram_en/ram_wen low combinationally while rst is high; no request accepted or written during reset.
REQ-026 SHALL drop a response pending from the cycle before reset (no rsp_valid in the cycle after the reset edge).

Verification
REQ-027 SHALL cover: LSU write addr 0x8000_0010, wdata 0x1122334455667788, wstrb 0x0F -> ram_wmask 0x0000_0000_FFFF_FFFF, ram_wen 1; next cycle lsu_rsp_valid 1, rdata 0, err 0.
REQ-028 SHALL cover: IFU fetch 0x8000_0004 with ram_rdata 0xAAAA_BBBB_CCCC_DDDD -> next cycle ifu_rsp_data 0xAAAA_BBBB; fetch 0x8000_0000 -> 0xCCCC_DDDD.
REQ-029 SHALL cover: both valids held high continuously, STARVE_LIMIT 4 -> grant pattern LSU,LSU,LSU,LSU,IFU repeating.
REQ-030 SHALL cover: LSU read 0x7FFF_FFF8 and IFU fetch RAM_BASE+RAM_BYTES -> ram_en 0, next cycle rsp_err 1, data 0.
REQ-031 SHALL cover: LSU accepted, rst asserted the following edge -> no lsu_rsp_valid after reset, starve_cnt 0, readies low during rst.
REQ-032 SHALL cover: alternating single IFU / single LSU requests every cycle -> one accept per cycle, each response exactly 1 cycle later.
